alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Front end of the ALU op interface. Accepts 9-bit instruction words over a valid/ready handshake and decodes them into the 4-bit ALU operation code plus operand fields.
- Buffers decoded ops in a small FIFO and issues them downstream to the ALU/execute stage over a second valid/ready handshake.
- Handles illegal encodings, the REST (halt) op, and issue counting. Sits between instruction fetch and the ALU.

Parameters:
- DEPTH, 2, decoded-op FIFO entries (power of 2, >=2)
- CNT_W, 16, width of issue_cnt_o and illegal_cnt_o

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid_i  in  1  instruction word valid
- in_ready_o  out  1  decoder can accept a word this cycle
- inst_i  in  9  instruction: [8:5] op, [4:3] ra, [2:0] imm
- out_valid_o  out  1  head FIFO entry valid
- out_ready_i  in  1  ALU side consumes head entry
- op_o  out  4  ALU op code: ADD=0 SUB=1 AND=2 OR=3 SLL=4 SRL=5 SLT=6 TWCMP=7 ABS=8 SLTU=9 REST=10
- ra_o  out  2  register field of head entry
- imm_o  out  3  immediate / shift amount / bit position of head entry
- resume_i  in  1  leave HALT (level sampled each cycle)
- halted_o  out  1  state == HALT (or TRAP when enabled)
- illegal_o  out  1  one-cycle pulse, cycle after an illegal word is accepted
- issue_cnt_o  out  CNT_W  count of entries popped downstream
- illegal_cnt_o  out  CNT_W  count of illegal words accepted

Behaviour:
- Reset: FIFO empty; state RUN. out_valid_o, illegal_o, halted_o, issue_cnt_o, illegal_cnt_o = 0. op_o/ra_o/imm_o = 0.
- States: RUN, HALT (plus TRAP with the optional feature).
- in_ready_o = (state==RUN) && FIFO not full. It is registered-state based only, with no combinational path from out_ready_i. A pop in the same cycle does not make a full FIFO ready.
- Accept = in_valid_i && in_ready_o.
- Legality:
  - op 0..10 legal; op 11..15 illegal.
  - TWCMP (7) legal only with imm in 1..5 (pattern bit position); imm 0, 6, 7 illegal.
  - SLL/SRL accept imm 0..7 as shift amount.
  - All other legal ops pass imm unchanged.
- Legal accept: push {op, ra, imm}. Entry is visible at the outputs the next cycle if the FIFO was empty (1-cycle latency).
- REST accept: entry is pushed and issued like any other op; state -> HALT next cycle.
- Illegal accept: nothing is pushed; illegal_o = 1 next cycle only; illegal_cnt_o += 1.
- Downstream:
  - out_valid_o = FIFO not empty.
  - Pop when out_valid_o && out_ready_i.
  - Outputs hold stable while out_valid_o && !out_ready_i.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and ordering is preserved.
- HALT:
  - in_ready_o = 0; the FIFO keeps draining.
  - resume_i = 1 moves HALT -> RUN next cycle.
  - resume_i is ignored in RUN.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation: FIFO contents are discarded, state returns to RUN, counters clear. Reset has priority over all other events in the same cycle.

Optional Feature:
- Macro: ALU_OP_DECODER_TRAP_EN.
- Defined:
  - An illegal accept also moves state RUN -> TRAP.
  - TRAP behaves like HALT: in_ready_o = 0, FIFO drains, halted_o = 1.
  - Only resume_i exits TRAP, to RUN.
- Undefined:
  - Illegal words are dropped with the illegal_o pulse and count only.
  - State remains RUN; no TRAP state exists.

Test Plan:
- Stream ADD(0x005), SUB(0x02A), SLTU(0x12F) with out_ready_i=1 -> op_o 0,1,9 in order, each 1 cycle after accept; issue_cnt_o=3.
- Hold out_ready_i=0 and push DEPTH=2 words -> in_ready_o=0 after 2 accepts. Raise out_ready_i with in_valid_i high -> no accept in that pop cycle; accept the next cycle; order preserved.
- TWCMP with imm=3 (0x0E3) -> issued op_o=7, imm_o=3. TWCMP imm=6 (0x0E6) -> not issued, illegal_o pulse, illegal_cnt_o=1. op=12 (0x180) -> illegal_cnt_o=2.
- REST (0x140), then ADD offered -> REST issued, halted_o=1, ADD stalled. Pulse resume_i -> halted_o=0 next cycle; ADD accepted after that.
- With ALU_OP_DECODER_TRAP_EN, inject op=15 -> halted_o=1, in_ready_o=0 until resume_i. Without the macro -> in_ready_o stays 1.
- Fill FIFO and assert halt, then reset for 1 cycle -> out_valid_o=0, counters 0, in_ready_o=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder
// Brief    : Decodes 9-bit instruction words ([8:5] op, [4:3] ra, [2:0] imm)
//            into ALU ops, buffers them in a DEPTH-entry FIFO and issues them
//            downstream over a valid/ready handshake. Handles illegal words,
//            the REST (halt) op and issue/illegal counting.
// Options  : `define ALU_OP_DECODER_TRAP_EN to make an illegal word also
//            trap the decoder until resume_i.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [8:0]       inst_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       op_o,
    output logic [1:0]       ra_o,
    output logic [2:0]       imm_o,
    input  logic             resume_i,
    output logic             halted_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] issue_cnt_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_HALT = 2'd1;
`ifdef ALU_OP_DECODER_TRAP_EN
    localparam logic [1:0] c_ST_TRAP = 2'd2;
`endif

    localparam logic [3:0] c_OP_TWCMP   = 4'd7;
    localparam logic [3:0] c_OP_REST    = 4'd10;
    localparam logic [3:0] c_OP_MAX_LEG = 4'd10;

    logic [1:0]         r_state;
    logic [8:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_issueCnt;
    logic [CNT_W-1:0]   r_illegalCnt;

    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_pop;
    logic       w_push;
    logic       w_legal;
    logic       w_twcmpBad;
    logic [3:0] w_op;
    logic [2:0] w_imm;
    logic [8:0] w_head;

    assign w_op    = inst_i[8:5];
    assign w_imm   = inst_i[2:0];
    assign w_full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // TWCMP names a pattern bit position, so only 1..5 are meaningful
    assign w_twcmpBad = (w_op == c_OP_TWCMP) && ((w_imm == 3'd0) || (w_imm > 3'd5));
    assign w_legal    = (w_op <= c_OP_MAX_LEG) && !w_twcmpBad;

    // Ready depends only on registered state: a same-cycle pop never frees a slot
    assign in_ready_o = (r_state == c_ST_RUN) && !w_full;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = !w_empty && out_ready_i;

    assign w_head      = r_mem[r_rdPtr];
    assign out_valid_o = !w_empty;
    // Fields read as zero while the FIFO is empty (including after reset)
    assign op_o        = w_empty ? 4'd0 : w_head[8:5];
    assign ra_o        = w_empty ? 2'd0 : w_head[4:3];
    assign imm_o       = w_empty ? 3'd0 : w_head[2:0];

    assign halted_o      = (r_state != c_ST_RUN);
    assign illegal_o     = r_illegal;
    assign issue_cnt_o   = r_issueCnt;
    assign illegal_cnt_o = r_illegalCnt;

    // FIFO storage: contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= inst_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Run/halt control: REST halts after issue is queued, resume_i restarts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_push && (w_op == c_OP_REST)) begin
                        r_state <= c_ST_HALT;
                    end
`ifdef ALU_OP_DECODER_TRAP_EN
                    else if (w_accept && !w_legal) begin
                        r_state <= c_ST_TRAP;
                    end
`endif
                end
                c_ST_HALT: begin
                    if (resume_i) begin
                        r_state <= c_ST_RUN;
                    end
                end
`ifdef ALU_OP_DECODER_TRAP_EN
                c_ST_TRAP: begin
                    if (resume_i) begin
                        r_state <= c_ST_RUN;
                    end
                end
`endif
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    // Illegal pulse and wrapping issue/illegal counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal    <= 1'b0;
            r_issueCnt   <= '0;
            r_illegalCnt <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_pop) begin
                r_issueCnt <= r_issueCnt + CNT_W'(1);
            end
            if (w_accept && !w_legal) begin
                r_illegalCnt <= r_illegalCnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_decoder
// Brief    : Self-checking bench for alu_op_decoder: directed vector table
//            followed by randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_decoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
`ifdef ALU_OP_DECODER_TRAP_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [8:0]       inst_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [3:0]       op_o;
    logic [1:0]       ra_o;
    logic [2:0]       imm_o;
    logic             resume_i;
    logic             halted_o;
    logic             illegal_o;
    logic [CNT_W-1:0] issue_cnt_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    alu_op_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .inst_i        (inst_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .op_o          (op_o),
        .ra_o          (ra_o),
        .imm_o         (imm_o),
        .resume_i      (resume_i),
        .halted_o      (halted_o),
        .illegal_o     (illegal_o),
        .issue_cnt_o   (issue_cnt_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: queue of pending words plus halt flag and counters
    logic [8:0]       mQ[$];
    bit               mHalt;
    bit               mIll;
    logic [CNT_W-1:0] mIssue;
    logic [CNT_W-1:0] mIllCnt;

    typedef struct {
        logic       rst;
        logic       v;
        logic [8:0] inst;
        logic       ordy;
        logic       res;
        logic       eValid;
        logic [3:0] eOp;
        logic [2:0] eImm;
        logic       eReady;
        logic       eHalt;
        logic       eIll;
        int         eIssue;
        int         eIllCnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit isLegal(input logic [8:0] w);
        int op;
        int imm;
        op  = int'(w[8:5]);
        imm = int'(w[2:0]);
        if (op > 10) return 1'b0;
        if (op == 7 && (imm < 1 || imm > 5)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelUpdate(input logic r, v, input logic [8:0] ins, input logic ordy, res);
        bit wasHalt;
        bit acc;
        bit popd;
        bit leg;
        if (r) begin
            mQ.delete();
            mHalt   = 1'b0;
            mIll    = 1'b0;
            mIssue  = '0;
            mIllCnt = '0;
        end else begin
            wasHalt = mHalt;
            acc     = v && !mHalt && (mQ.size() < DEPTH);
            popd    = (mQ.size() > 0) && ordy;
            leg     = isLegal(ins);
            mIll    = acc && !leg;
            if (popd) begin
                void'(mQ.pop_front());
                mIssue = mIssue + 1'b1;
            end
            if (acc && leg) begin
                mQ.push_back(ins);
                if (int'(ins[8:5]) == 10) mHalt = 1'b1;
            end
            if (acc && !leg) begin
                mIllCnt = mIllCnt + 1'b1;
                if (TR) mHalt = 1'b1;
            end
            if (wasHalt && res) mHalt = 1'b0;
        end
    endtask

    task automatic modelCheck();
        logic [8:0] h;
        chk("out_valid", int'(out_valid_o), int'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            h = mQ[0];
            chk("op", int'(op_o), int'(h[8:5]));
            chk("ra", int'(ra_o), int'(h[4:3]));
            chk("imm", int'(imm_o), int'(h[2:0]));
        end
        chk("in_ready", int'(in_ready_o), int'(!mHalt && (mQ.size() < DEPTH)));
        chk("halted", int'(halted_o), int'(mHalt));
        chk("illegal", int'(illegal_o), int'(mIll));
        chk("issue_cnt", int'(issue_cnt_o), int'(mIssue));
        chk("illegal_cnt", int'(illegal_cnt_o), int'(mIllCnt));
    endtask

    // One clock: inputs driven at negedge, model stepped at the edge, outputs
    // compared at the following negedge
    task automatic step(input logic r, v, input logic [8:0] ins, input logic ordy, res);
        reset       = r;
        in_valid_i  = v;
        inst_i      = ins;
        out_ready_i = ordy;
        resume_i    = res;
        @(posedge clk);
        modelUpdate(r, v, ins, ordy, res);
        @(negedge clk);
        modelCheck();
    endtask

    function automatic vec_t mk(input logic r, v, input logic [8:0] ins, input logic ordy, res,
                                input logic ev, input logic [3:0] eop, input logic [2:0] eimm,
                                input logic erdy, eh, eil, input int eis, eic);
        vec_t t;
        t.rst = r; t.v = v; t.inst = ins; t.ordy = ordy; t.res = res;
        t.eValid = ev; t.eOp = eop; t.eImm = eimm; t.eReady = erdy;
        t.eHalt = eh; t.eIll = eil; t.eIssue = eis; t.eIllCnt = eic;
        return t;
    endfunction

    initial begin
        reset = 1'b1; in_valid_i = 1'b0; inst_i = '0; out_ready_i = 1'b0; resume_i = 1'b0;

        //                rst v  inst    ordy res  val op  imm rdy  halt ill iss ilc
        tbl.push_back(mk(1, 0, 9'h000, 0, 0,   0,  0,  0,  1,   0,   0,  0,  0));
        // streaming ADD, SUB, SLTU
        tbl.push_back(mk(0, 1, 9'h005, 1, 0,   1,  0,  5,  1,   0,   0,  0,  0));
        tbl.push_back(mk(0, 1, 9'h02A, 1, 0,   1,  1,  2,  1,   0,   0,  1,  0));
        tbl.push_back(mk(0, 1, 9'h12F, 1, 0,   1,  9,  7,  1,   0,   0,  2,  0));
        tbl.push_back(mk(0, 0, 9'h000, 1, 0,   0,  0,  0,  1,   0,   0,  3,  0));
        // fill with consumer stalled, then pop while offering
        tbl.push_back(mk(0, 1, 9'h005, 0, 0,   1,  0,  5,  1,   0,   0,  3,  0));
        tbl.push_back(mk(0, 1, 9'h02A, 0, 0,   1,  0,  5,  0,   0,   0,  3,  0));
        tbl.push_back(mk(0, 1, 9'h12F, 1, 0,   1,  1,  2,  1,   0,   0,  4,  0));
        tbl.push_back(mk(0, 1, 9'h12F, 0, 0,   1,  1,  2,  0,   0,   0,  4,  0));
        tbl.push_back(mk(0, 0, 9'h000, 1, 0,   1,  9,  7,  1,   0,   0,  5,  0));
        tbl.push_back(mk(0, 0, 9'h000, 1, 0,   0,  0,  0,  1,   0,   0,  6,  0));
        // TWCMP legal / illegal, op 12
        tbl.push_back(mk(0, 1, 9'h0E3, 1, 0,   1,  7,  3,  1,   0,   0,  6,  0));
        tbl.push_back(mk(0, 1, 9'h0E6, 1, 0,   0,  0,  0,  !TR, TR,  1,  7,  1));
        tbl.push_back(mk(0, 0, 9'h000, 1, 1,   0,  0,  0,  1,   0,   0,  7,  1));
        tbl.push_back(mk(0, 1, 9'h180, 1, 0,   0,  0,  0,  !TR, TR,  1,  7,  2));
        tbl.push_back(mk(0, 0, 9'h000, 1, 1,   0,  0,  0,  1,   0,   0,  7,  2));
        // REST halts, ADD stalls until resume
        tbl.push_back(mk(0, 1, 9'h140, 1, 0,   1, 10,  0,  0,   1,   0,  7,  2));
        tbl.push_back(mk(0, 1, 9'h005, 1, 0,   0,  0,  0,  0,   1,   0,  8,  2));
        tbl.push_back(mk(0, 1, 9'h005, 1, 1,   0,  0,  0,  1,   0,   0,  8,  2));
        tbl.push_back(mk(0, 1, 9'h005, 1, 0,   1,  0,  5,  1,   0,   0,  8,  2));
        tbl.push_back(mk(0, 0, 9'h000, 1, 0,   0,  0,  0,  1,   0,   0,  9,  2));
        // op 15: traps only with the option enabled
        tbl.push_back(mk(0, 1, 9'h1E0, 1, 0,   0,  0,  0,  !TR, TR,  1,  9,  3));
        tbl.push_back(mk(0, 0, 9'h000, 1, 0,   0,  0,  0,  !TR, TR,  0,  9,  3));
        tbl.push_back(mk(0, 0, 9'h000, 1, 1,   0,  0,  0,  1,   0,   0,  9,  3));
        // fill, halt, then reset with competing traffic
        tbl.push_back(mk(0, 1, 9'h005, 0, 0,   1,  0,  5,  1,   0,   0,  9,  3));
        tbl.push_back(mk(0, 1, 9'h140, 0, 0,   1,  0,  5,  0,   1,   0,  9,  3));
        tbl.push_back(mk(1, 1, 9'h005, 1, 0,   0,  0,  0,  1,   0,   0,  0,  0));
        tbl.push_back(mk(0, 0, 9'h000, 0, 0,   0,  0,  0,  1,   0,   0,  0,  0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].inst, tbl[i].ordy, tbl[i].res);
            chk($sformatf("vec%0d.valid", i), int'(out_valid_o), int'(tbl[i].eValid));
            if (tbl[i].eValid) begin
                chk($sformatf("vec%0d.op", i), int'(op_o), int'(tbl[i].eOp));
                chk($sformatf("vec%0d.imm", i), int'(imm_o), int'(tbl[i].eImm));
            end
            if (tbl[i].rst) begin
                chk($sformatf("vec%0d.rst_op", i), int'(op_o), 0);
                chk($sformatf("vec%0d.rst_ra", i), int'(ra_o), 0);
                chk($sformatf("vec%0d.rst_imm", i), int'(imm_o), 0);
            end
            chk($sformatf("vec%0d.ready", i), int'(in_ready_o), int'(tbl[i].eReady));
            chk($sformatf("vec%0d.halted", i), int'(halted_o), int'(tbl[i].eHalt));
            chk($sformatf("vec%0d.illegal", i), int'(illegal_o), int'(tbl[i].eIll));
            chk($sformatf("vec%0d.issue_cnt", i), int'(issue_cnt_o), tbl[i].eIssue);
            chk($sformatf("vec%0d.illegal_cnt", i), int'(illegal_cnt_o), tbl[i].eIllCnt);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 7),
                 9'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
